arb4_rr: RTL and testbench
==========================

# arb4_rr

Four-requester arbiter that shares one downstream resource, such as the encoded-select datapath fed by our 4-to-2 priority encoders, between up to four masters. It supports two priority modes: fixed priority, where req[3] is highest (the same ordering as our priority encoders), and rotating round-robin priority. A grant is held until its owner releases it or a hold-timeout pre-empts it. Outputs are registered one-hot and encoded grants, so downstream select muxes can use them directly.

## Interface
- MAX_HOLD, default 16: maximum consecutive cycles one owner may hold the grant while others request. 0 disables pre-emption. Legal range 0..255.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  arbiter enable. When low, no grant is held or issued.
- rr_mode  in  1  priority mode. 1 = round-robin, 0 = fixed priority (req[3] > req[2] > req[1] > req[0]).
- req  in  4  request vector, one bit per master. A master holds its bit high for the whole transaction.
- gnt  out  4  one-hot grant, registered. All zeros means no owner.
- gnt_idx  out  2  binary index of the owner, registered. Valid only when gnt_vld=1.
- gnt_vld  out  1  high while any grant is active. Equals the OR of gnt.

## Operation
- State machine with two states, IDLE and OWNED.
- IDLE:
  - If en=1 and req≠0, pick a winner and go to OWNED.
  - Otherwise stay in IDLE with gnt=0.
- OWNED, owner index k:
  - Stay while en=1, req[k]=1 and no timeout occurs.
  - If req[k]=0, re-arbitrate over the current req. If no request is pending, go to IDLE; otherwise move directly to the new winner with no idle cycle.
  - If en=0, go to IDLE.
- Fixed mode: the winner is the highest set index of req.
- Round-robin mode:
  - A 2-bit pointer ptr names the highest-priority index.
  - Priority order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - On every new grant to index w, ptr becomes (w+1) mod 4.
  - ptr is not updated in fixed mode.
  - ptr is retained across mode switches.
- Timeout:
  - hold_cnt (8 bits) clears on every new grant and increments each cycle the state stays OWNED. It saturates at 255.
  - Pre-emption happens when MAX_HOLD≠0, hold_cnt==MAX_HOLD-1, and some other req bit (excluding k) is set.
  - On pre-emption, the arbiter re-arbitrates over req with bit k masked. The winner is guaranteed to be a different master.
  - If no other master requests, the owner keeps the grant indefinitely.
- Arbitration always uses req as sampled at that clock edge. Requests are not latched or queued.
- The same owner may be re-granted immediately after it releases, if it is again the winner at a later edge.

## Timing
- Reset values, forced asynchronously while rst_n=0: gnt=4'b0000, gnt_idx=2'b00, gnt_vld=0, ptr=0, hold_cnt=0, state=IDLE.
- Grant latency is 1 cycle: req rises before edge N, and gnt is valid after edge N.
- Release latency is 1 cycle: when the owner drops req before edge N, gnt changes (to 0 or to the next owner) after edge N.
- The grant is held for MAX_HOLD cycles before pre-emption, counting the grant cycle as cycle 1.
- Mode changes (rr_mode) never pre-empt the current owner. The new mode applies only at the next arbitration.
- If en falls while OWNED, gnt clears after the next edge. No grant is issued while en=0.
- Reset asserted mid-transaction clears everything immediately. There is no replay after reset.
- gnt, gnt_idx and gnt_vld change only at rising edges (or at reset). They never glitch and are always consistent with each other.

## Structure
- Package arb_pkg holds:
  - the state enum arb_state_t {IDLE, OWNED};
  - the constant NUM_REQ=4;
  - the typedef idx_t (logic [1:0]).
- Sub-module pri_enc4_rot, combinational:
  - Inputs: req[3:0], ptr[1:0], rr, mask[3:0].
  - Outputs: idx[1:0], any.
  - Rotation: rotate req right by ptr, pick the highest priority, then rotate the index back. In fixed mode, pick the highest set index.
- The top level contains only the state register, ptr, hold_cnt and the output registers.

## Test plan
- Reset and basic grant: hold rst_n low, expect all outputs 0. Release reset, set req=4'b0101 with rr_mode=0. After 1 edge, expect gnt=4'b0100, gnt_idx=2, gnt_vld=1.
- Release handoff: while master 2 is owner, change req to 4'b0001. After 1 edge, expect gnt=4'b0001 with no zero cycle in between. Then set req=0; after 1 edge, expect gnt=0 and gnt_vld=0.
- Round-robin fairness: rr_mode=1, ptr=0. Each master holds req=4'b1111 and releases its own bit for one cycle after 1 cycle of ownership. Expect grant order 0,1,2,3,0.
- Timeout: MAX_HOLD=4, rr_mode=1. Hold req[1] high, then raise req[3] on cycle 2. Expect gnt=4'b0010 for exactly 4 cycles, then 4'b1000. With req[1] alone, expect no pre-emption after 20 cycles.
- Enable drop and mid-operation reset:
  - With owner 3, drive en=0: expect gnt=0 after 1 edge, and no grant while en=0.
  - Re-enable en with req=4'b1000: expect gnt=4'b1000 after 1 edge.
  - Pulse rst_n low asynchronously: expect outputs cleared before the next edge and ptr=0.

Source files
------------

// File: rtl/arb4_rr_pkg.sv
// Shared types and constants for the four-requester arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ = 4;

  typedef logic [1:0] idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/pri_enc4_rot.sv
// Combinational winner select: fixed (highest index wins) or rotating priority from ptr.
module pri_enc4_rot
  import arb_pkg::*;
(
  input  logic [3:0] req,
  input  idx_t       ptr,
  input  logic       rr,
  input  logic [3:0] mask,
  output idx_t       idx,
  output logic       any
);

  logic [3:0] masked;
  logic [3:0] rot;
  idx_t       src;
  idx_t       pos;

  always_comb begin
    masked = req & ~mask;
    any    = |masked;
    rot    = '0;
    idx    = '0;
    src    = '0;
    pos    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      src    = idx_t'(i) + ptr;
      rot[i] = masked[src];
    end
    // Scan from lowest to highest priority so the last hit is the winner.
    if (rr) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        pos = idx_t'(NUM_REQ - 1 - i);
        if (rot[pos]) idx = pos + ptr;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (masked[i]) idx = idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/arb4_rr.sv
// Four-requester arbiter with fixed/round-robin priority, hold-until-release and hold timeout.
module arb4_rr
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       rr_mode,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld
);

  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  arb_state_t state_q, state_d;
  idx_t       ptr_q, ptr_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] gnt_q, gnt_d;
  idx_t       idx_q, idx_d;

  logic [3:0] own_oh;
  logic [3:0] enc_mask;
  logic       timeout;
  idx_t       win_idx;
  logic       win_any;

  assign own_oh  = 4'b0001 << idx_q;
  assign timeout = (MAX_HOLD != 0) && (hold_q == HOLD_LAST) && |(req & ~own_oh);
  // Mask the owner only when it is being pre-empted, so the winner is someone else.
  assign enc_mask = (state_q == OWNED && req[idx_q] && timeout) ? own_oh : 4'b0000;

  pri_enc4_rot u_enc (
    .req (req),
    .ptr (ptr_q),
    .rr  (rr_mode),
    .mask(enc_mask),
    .idx (win_idx),
    .any (win_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (en && win_any) begin
          state_d = OWNED;
          gnt_d   = 4'b0001 << win_idx;
          idx_d   = win_idx;
          hold_d  = '0;
          if (rr_mode) ptr_d = win_idx + 2'd1;
        end
      end
      OWNED: begin
        if (!en || (!req[idx_q] && !win_any)) begin
          state_d = IDLE;
          gnt_d   = '0;
          idx_d   = '0;
          hold_d  = '0;
        end else if (!req[idx_q] || timeout) begin
          gnt_d  = 4'b0001 << win_idx;
          idx_d  = win_idx;
          hold_d = '0;
          if (rr_mode) ptr_d = win_idx + 2'd1;
        end else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = |gnt_q;

endmodule

// File: tb/tb_arb4_rr.sv
// Directed self-checking bench for arb4_rr with MAX_HOLD=4.
module tb_arb4_rr;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       rr_mode;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;

  int checks;
  int failures;

  arb4_rr #(.MAX_HOLD(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .rr_mode(rr_mode),
    .req    (req),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .gnt_vld(gnt_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] ei, input logic ev);
    checks++;
    assert ({gnt, gnt_idx, gnt_vld} === {eg, ei, ev})
    else begin
      failures++;
      $error("FAIL %s: gnt=%b idx=%0d vld=%b, expected gnt=%b idx=%0d vld=%b",
             tag, gnt, gnt_idx, gnt_vld, eg, ei, ev);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    rr_mode  = 1'b0;
    req      = 4'b0000;
    #2;
    chk("reset_async", 4'b0000, 2'd0, 1'b0);
    step(); step();
    chk("reset_hold", 4'b0000, 2'd0, 1'b0);

    // Fixed mode basic grant and handoff
    rst_n = 1'b1; en = 1'b1; req = 4'b0101;
    step(); chk("fixed_grant", 4'b0100, 2'd2, 1'b1);
    req = 4'b0001;
    step(); chk("handoff", 4'b0001, 2'd0, 1'b1);
    req = 4'b0000;
    step(); chk("release_idle", 4'b0000, 2'd0, 1'b0);

    // Round-robin fairness from ptr=0
    rr_mode = 1'b1; req = 4'b1111;
    step(); chk("rr_0", 4'b0001, 2'd0, 1'b1);
    req = 4'b1110;
    step(); chk("rr_1", 4'b0010, 2'd1, 1'b1);
    req = 4'b1101;
    step(); chk("rr_2", 4'b0100, 2'd2, 1'b1);
    req = 4'b1011;
    step(); chk("rr_3", 4'b1000, 2'd3, 1'b1);
    req = 4'b0111;
    step(); chk("rr_wrap", 4'b0001, 2'd0, 1'b1);
    req = 4'b0000;
    step(); chk("rr_idle", 4'b0000, 2'd0, 1'b0);

    // Timeout: ptr=1; master 1 owns for 4 cycles, then master 3 pre-empts
    req = 4'b0010;
    step(); chk("to_c1", 4'b0010, 2'd1, 1'b1);
    req = 4'b1010;
    step(); chk("to_c2", 4'b0010, 2'd1, 1'b1);
    step(); chk("to_c3", 4'b0010, 2'd1, 1'b1);
    step(); chk("to_c4", 4'b0010, 2'd1, 1'b1);
    step(); chk("to_preempt", 4'b1000, 2'd3, 1'b1);

    // Lone requester is never pre-empted
    req = 4'b0010;
    step(); chk("lone_grant", 4'b0010, 2'd1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(); chk("lone_hold", 4'b0010, 2'd1, 1'b1);
    end

    // Enable drop with owner 3 (fixed mode keeps ptr at 2)
    rr_mode = 1'b0; req = 4'b1000;
    step(); chk("own3", 4'b1000, 2'd3, 1'b1);
    en = 1'b0;
    step(); chk("en_drop", 4'b0000, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(); chk("en_low", 4'b0000, 2'd0, 1'b0);
    end
    en = 1'b1;
    step(); chk("en_back", 4'b1000, 2'd3, 1'b1);

    // Asynchronous mid-transaction reset, then confirm ptr returned to 0
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset", 4'b0000, 2'd0, 1'b0);
    rr_mode = 1'b1; req = 4'b1111;
    #1;
    rst_n = 1'b1;
    step(); chk("ptr_reset", 4'b0001, 2'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
